// File: rtl/sram_event_fifo_pkg.sv
// sram_event_fifo_pkg
// Shared helpers for the SRAM-backed event FIFO:
//   BYTE_W       - bits per write-mask lane
//   addr_width() - SRAM address width for a given depth
//   level_width()- width of the occupancy count (SRAM words plus head register)
//   ptr_wrap()   - next value of a pointer that wraps DEPTH-1 -> 0
package sram_event_fifo_pkg;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // The head register can hold one word beyond the SRAM, so the count runs to DEPTH+1.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

  // Depth need not be a power of two, so the wrap is an explicit compare.
  function automatic int unsigned ptr_wrap(input int unsigned p, input int unsigned depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/sram_fifo_ptr.sv
// sram_fifo_ptr
// Wrapping SRAM address pointer, 0..DEPTH-1.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset, returns the pointer to 0
//   inc - advance the pointer by one (wrapping) at the next edge
//   ptr - current pointer value
module sram_fifo_ptr
  import sram_event_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= AW'(ptr_wrap(32'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/sram_event_fifo.sv
// sram_event_fifo
// Valid/ready FIFO controller using an external dual-port SRAM as storage.
// Port A only writes, port B only reads. The SRAM's registered read output is
// presented directly as the head entry, and out_valid tracks whether that
// registered word is a live entry, hiding the one-cycle read latency.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready/in_data     - push stream
//   out_valid/out_ready/out_data  - pop stream (out_data is rdata_b)
//   level                         - SRAM words plus presented head
//   almost_full                   - only with SRAM_EVENT_FIFO_ALMOST_FULL_EN defined
//   ce_a/we_a/addr_a/wmask_a/wdata_a - SRAM write port
//   ce_b/we_b/addr_b/wmask_b/wdata_b - SRAM read port (write controls tied off)
//   rdata_b                       - SRAM registered read data
// Optional feature macro: SRAM_EVENT_FIFO_ALMOST_FULL_EN
module sram_event_fifo
  import sram_event_fifo_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_THRESH = DEPTH - 2,
  localparam int unsigned AW = addr_width(DEPTH),
  localparam int unsigned LW = level_width(DEPTH),
  localparam int unsigned MW = WIDTH / BYTE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    level,
`ifdef SRAM_EVENT_FIFO_ALMOST_FULL_EN
  output logic             almost_full,
`endif
  output logic             ce_a,
  output logic             we_a,
  output logic [AW-1:0]    addr_a,
  output logic [MW-1:0]    wmask_a,
  output logic [WIDTH-1:0] wdata_a,
  output logic             ce_b,
  output logic             we_b,
  output logic [AW-1:0]    addr_b,
  output logic [MW-1:0]    wmask_b,
  output logic [WIDTH-1:0] wdata_b,
  input  logic [WIDTH-1:0] rdata_b
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] sram_cnt;
  logic          push;
  logic          rd_issue;

  // in_ready looks only at registered occupancy so out_ready never reaches it
  // combinationally. A read is issued only when the SRAM holds a word, which
  // also keeps the two ports off the same address.
  assign in_ready = !rst && (sram_cnt != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign rd_issue = !rst && (sram_cnt != '0) && (!out_valid || out_ready);

  assign ce_a    = push;
  assign we_a    = push;
  assign addr_a  = wr_ptr;
  assign wmask_a = '1;
  assign wdata_a = in_data;

  assign ce_b    = rd_issue;
  assign we_b    = 1'b0;
  assign addr_b  = rd_ptr;
  assign wmask_b = '0;
  assign wdata_b = '0;

  assign out_data = rdata_b;
  assign level    = sram_cnt + LW'(out_valid);

  sram_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  sram_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_issue),
    .ptr (rd_ptr)
  );

  // The SRAM returns read data one edge after the issue, so out_valid is set by
  // the issue and held until the head is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      sram_cnt  <= sram_cnt + LW'(push) - LW'(rd_issue);
      out_valid <= rd_issue || (out_valid && !out_ready);
    end
  end

`ifdef SRAM_EVENT_FIFO_ALMOST_FULL_EN
  // Registered from the current level, so it trails level by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (32'(level) >= AFULL_THRESH);
    end
  end
`else
  // The threshold has no function without the almost-full output.
  logic unused_afull_thresh;
  assign unused_afull_thresh = ^AFULL_THRESH;
`endif

endmodule

// File: tb/tb_sram_event_fifo.sv
// tb_sram_event_fifo
// Bench for sram_event_fifo with a behavioural dual-port SRAM and a queue-based
// reference model of the FIFO (SRAM contents plus a presented head word).
module tb_sram_event_fifo;

  localparam int TW = 16;
  localparam int TD = 16;
  localparam int TA = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_data;
  logic [4:0]    level;
`ifdef SRAM_EVENT_FIFO_ALMOST_FULL_EN
  logic          almost_full;
`endif
  logic          ce_a, we_a, ce_b, we_b;
  logic [3:0]    addr_a, addr_b;
  logic [1:0]    wmask_a, wmask_b;
  logic [TW-1:0] wdata_a, wdata_b;
  logic [TW-1:0] rdata_b = '0;
  logic [TW-1:0] mem [TD];

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [TW-1:0] sq[$];
  logic          hv = 1'b0;
  logic [TW-1:0] hd = '0;
  logic          af = 1'b0;
  logic          last_push;
  logic          last_pop;

  typedef struct {
    logic          r, iv;
    logic [TW-1:0] d;
    logic          ordy;
    logic          e_rdy, e_ov;
    logic [4:0]    e_lvl;
    logic          e_cea, e_ceb;
    logic [TW-1:0] e_data;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  sram_event_fifo #(.WIDTH(TW), .DEPTH(TD), .AFULL_THRESH(TA)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
`ifdef SRAM_EVENT_FIFO_ALMOST_FULL_EN
    .almost_full(almost_full),
`endif
    .ce_a(ce_a), .we_a(we_a), .addr_a(addr_a), .wmask_a(wmask_a), .wdata_a(wdata_a),
    .ce_b(ce_b), .we_b(we_b), .addr_b(addr_b), .wmask_b(wmask_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b)
  );

  // Behavioural SRAM: byte-masked write on A, registered read on B that holds when idle.
  always @(posedge clk) begin
    if (ce_a && we_a) begin
      for (int b = 0; b < 2; b++) begin
        if (wmask_a[b]) mem[addr_a][b*8 +: 8] <= wdata_a[b*8 +: 8];
      end
    end
    if (ce_b) rdata_b <= mem[addr_b];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after the falling edge and settle before sampling.
  task automatic applyStimulus(input logic r, input logic iv, input logic [TW-1:0] d, input logic ordy);
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  // Compare every observable against the model's view of the current cycle.
  task automatic checkOutput();
    logic exp_rdy, exp_issue;
    exp_rdy   = !rst && (sq.size() != TD);
    exp_issue = !rst && (sq.size() != 0) && (!hv || out_ready);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(hv));
    check("level", 32'(level), 32'(sq.size()) + 32'(hv));
    check("ce_a", 32'(ce_a), 32'(in_valid && exp_rdy));
    check("ce_b", 32'(ce_b), 32'(exp_issue));
    check("we_b", 32'(we_b), 32'd0);
    if (hv) check("out_data", 32'(out_data), 32'(hd));
    if (in_valid && exp_rdy) begin
      check("we_a", 32'(we_a), 32'd1);
      check("wmask_a", 32'(wmask_a), 32'h3);
      check("wdata_a", 32'(wdata_a), 32'(in_data));
    end
    if (ce_a && ce_b) check("port_collision", 32'(addr_a != addr_b), 32'd1);
`ifdef SRAM_EVENT_FIFO_ALMOST_FULL_EN
    check("almost_full", 32'(almost_full), 32'(af));
`endif
  endtask

  // Advance the model across the coming rising edge using the driven inputs.
  task automatic stepModel();
    logic rdy, issue;
    int   lvl;
    rdy       = !rst && (sq.size() != TD);
    issue     = !rst && (sq.size() != 0) && (!hv || out_ready);
    lvl       = sq.size() + int'(hv);
    last_push = in_valid && rdy;
    last_pop  = !rst && hv && out_ready;
    if (rst) begin
      sq.delete();
      hv = 1'b0;
      af = 1'b0;
    end else begin
      af = (lvl >= TA);
      if (hv && out_ready) hv = 1'b0;
      if (issue) begin
        hd = sq.pop_front();
        hv = 1'b1;
      end
      if (last_push) sq.push_back(in_data);
    end
  endtask

  task automatic cycle(input logic r, input logic iv, input logic [TW-1:0] d, input logic ordy);
    applyStimulus(r, iv, d, ordy);
    checkOutput();
    stepModel();
  endtask

  initial begin
    logic [TW-1:0] popped[$];
    int            n;
    logic          seen;

    // reset: first cycle DUT state is unknown, so it is not compared
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    stepModel();
    cycle(1'b1, 1'b1, 16'hFFFF, 1'b0);

    // single word, hand-derived expectations
    vecs[0] = '{1'b0, 1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 16'h0};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 16'h0};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 16'hA5A5};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 16'hA5A5};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 16'h0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].r, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      checkOutput();
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
      check($sformatf("vec%0d_ce_a", i), 32'(ce_a), 32'(vecs[i].e_cea));
      check($sformatf("vec%0d_ce_b", i), 32'(ce_b), 32'(vecs[i].e_ceb));
      if (vecs[i].e_ov) check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_data));
      stepModel();
    end

    // fill with no pops: 16 SRAM words plus the head
    n = 0;
    for (int i = 0; i < 22; i++) begin
      cycle(1'b0, 1'b1, TW'(n), 1'b0);
      if (last_push) n++;
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput();
    check("fill_accepted", 32'(n), 32'd17);
    check("fill_level", 32'(level), 32'd17);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_head", 32'(out_data), 32'd0);
    stepModel();
    popped.delete();
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput();
      if (out_valid) popped.push_back(out_data);
      stepModel();
    end
    check("fill_drain_count", 32'(popped.size()), 32'd17);
    for (int i = 0; i < popped.size(); i++) check($sformatf("fill_order%0d", i), 32'(popped[i]), 32'(i));

    // streaming across two pointer wraps
    n = 0;
    popped.delete();
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, n < 40, TW'(16'h100 + n), 1'b1);
      checkOutput();
      if (out_valid) popped.push_back(out_data);
      stepModel();
      if (last_push) n++;
    end
    check("stream_count", 32'(popped.size()), 32'd40);
    for (int i = 0; i < popped.size(); i++) begin
      if (popped[i] != TW'(16'h100 + i)) check("stream_order", 32'(popped[i]), 32'(16'h100 + i));
    end

    // backpressure: out_ready alternates while pushes arrive at random
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'($urandom_range(0, 1)), TW'($urandom), i[0] == 1'b0);

    // reset with 9 entries held
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, TW'(16'h900 + i), 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput();
    check("prereset_level", 32'(level), 32'd9);
    stepModel();
    cycle(1'b1, 1'b1, 16'hDEAD, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
    checkOutput();
    check("postreset_level", 32'(level), 32'd0);
    check("postreset_out_valid", 32'(out_valid), 32'd0);
    stepModel();
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput();
      if (out_valid) begin
        seen = 1'b1;
        check("postreset_first", 32'(out_data), 32'h1234);
      end
      stepModel();
    end
    check("postreset_seen", 32'(seen), 32'd1);

`ifdef SRAM_EVENT_FIFO_ALMOST_FULL_EN
    // almost_full trails level by one cycle in both directions
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1, TW'(i), 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput();
    check("af_level14", 32'(level), 32'd14);
    stepModel();
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput();
    check("af_rise", 32'(almost_full), 32'd1);
    stepModel();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput();
    check("af_level13", 32'(level), 32'd13);
    check("af_hold", 32'(almost_full), 32'd1);
    stepModel();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput();
    check("af_fall", 32'(almost_full), 32'd0);
    stepModel();
`endif

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), TW'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
